// File: rtl/edge_event_unit_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// edge_event_unit_pkg : mode encodings, prime FSM states, direction helper
// Revision 1.0
// ---------------------------------------------------------------------------
package edge_event_unit_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    PRIME_S = 2'b00,
    LOAD_S  = 2'b01,
    RUN_S   = 2'b10
  } prime_state_e;

  function automatic logic mode_accepts(input logic [1:0] mode, input logic rising);
    if (rising) return (mode == MODE_RISE) || (mode == MODE_BOTH);
    else        return (mode == MODE_FALL) || (mode == MODE_BOTH);
  endfunction

endpackage
`default_nettype wire

// File: rtl/edge_event_unit_edge_channel.sv
`default_nettype none
// ---------------------------------------------------------------------------
// edge_channel : sync chain, debounce filter, edge qualify, pending/overrun
// Revision 1.0
// ---------------------------------------------------------------------------
module edge_channel
  import edge_event_unit_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sig_in,
  input  logic [1:0] mode,
  input  logic       clear,
  input  logic       load,
  input  logic       run,
  output logic       pulse,
  output logic       pending,
  output logic       overrun
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   filt;
  logic [CW-1:0]          cnt;
  logic                   accept;
  logic                   qual_event;

  assign s          = sync[SYNC_STAGES-1];
  assign accept     = run && (s != filt) && (cnt == CNT_MAX);
  // s is the new filtered level, so it also gives the edge direction
  assign qual_event = accept && mode_accepts(mode, s);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync    <= '0;
      filt    <= 1'b0;
      cnt     <= '0;
      pulse   <= 1'b0;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sig_in};
      if (load) begin
        filt <= s;
        cnt  <= '0;
      end else if (run) begin
        if (s == filt) begin
          cnt <= '0;
        end else if (cnt == CNT_MAX) begin
          filt <= s;
          cnt  <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
      pulse   <= qual_event;
      // a new event beats clear for pending; clear beats a new overrun
      pending <= qual_event | (pending & ~clear);
      overrun <= ~clear & (overrun | (qual_event & pending));
    end
  end

endmodule
`default_nettype wire

// File: rtl/edge_event_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// edge_event_unit : multi-channel debounced edge detector with sticky IRQ
// Revision 1.0
// ---------------------------------------------------------------------------
module edge_event_unit
  import edge_event_unit_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   sig_in,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]   irq_en,
  input  logic [CHANNELS-1:0]   clear,
  output logic [CHANNELS-1:0]   pulse,
  output logic [CHANNELS-1:0]   pending,
  output logic [CHANNELS-1:0]   overrun,
  output logic                  irq
);

  localparam int            PW         = $clog2(SYNC_STAGES);
  localparam logic [PW-1:0] PRIME_LAST = PW'(SYNC_STAGES - 1);

  prime_state_e  state, state_nxt;
  logic [PW-1:0] prime_cnt, prime_cnt_nxt;
  logic          load;
  logic          run;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= PRIME_S;
      prime_cnt <= '0;
    end else begin
      state     <= state_nxt;
      prime_cnt <= prime_cnt_nxt;
    end
  end

  // Flush the synchronisers, then seed filt from s so levels held
  // through reset never look like an edge.
  always_comb begin
    state_nxt     = state;
    prime_cnt_nxt = prime_cnt;
    load          = 1'b0;
    run           = 1'b0;
    case (state)
      PRIME_S: begin
        if (prime_cnt == PRIME_LAST) begin
          state_nxt     = LOAD_S;
          prime_cnt_nxt = '0;
        end else begin
          prime_cnt_nxt = prime_cnt + PW'(1);
        end
      end
      LOAD_S: begin
        load      = 1'b1;
        state_nxt = RUN_S;
      end
      RUN_S:   run = 1'b1;
      default: state_nxt = PRIME_S;
    endcase
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    edge_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk    (clk),
      .reset  (reset),
      .sig_in (sig_in[i]),
      .mode   (mode[2*i+1:2*i]),
      .clear  (clear[i]),
      .load   (load),
      .run    (run),
      .pulse  (pulse[i]),
      .pending(pending[i]),
      .overrun(overrun[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq <= 1'b0;
    else       irq <= |(pending & irq_en);
  end

endmodule
`default_nettype wire
